vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, the framebuffer word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, the framebuffer word width.
REQ-003 SHALL have parameter WR_MAX_WAIT, default 8, the number of consecutive writer stall cycles that forces a writer slot (range 1..255).
REQ-004 SHALL have port MAX10_CLK1_50  in  1  system/pixel clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port disp_req  in  1  scanout fetch request, held until accepted.
REQ-007 SHALL have port disp_addr  in  ADDR_W  scanout fetch word address.
REQ-008 SHALL have port disp_ack  out  1  scanout request accepted this cycle.
REQ-009 SHALL have port disp_data  out  DATA_W  fetched word.
REQ-010 SHALL have port disp_valid  out  1  disp_data valid this cycle.
REQ-011 SHALL have port wr_req  in  1  host write request, held until accepted.
REQ-012 SHALL have port wr_addr  in  ADDR_W  host write word address.
REQ-013 SHALL have port wr_data  in  DATA_W  host write word.
REQ-014 SHALL have port wr_ack  out  1  host write accepted this cycle.
REQ-015 SHALL have port mem_addr  out  ADDR_W  single-port RAM address, registered.
REQ-016 SHALL have port mem_wdata  out  DATA_W  RAM write data, registered.
REQ-017 SHALL have port mem_we  out  1  RAM write enable, registered.
REQ-018 SHALL have port mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address was presented with mem_we=0.

Function
REQ-019 SHALL complete a transfer in the cycle where req and ack are both high; disp_ack and wr_ack are combinational from the requests and the wait counter, with at most one ack per cycle.
REQ-020 SHALL give the display priority: when disp_req=1 and wait_cnt<WR_MAX_WAIT, disp_ack=1 and wr_ack=0.
REQ-021 SHALL grant the writer (wr_ack=1) when wr_req=1 and either disp_req=0 or wait_cnt==WR_MAX_WAIT; disp_ack is 0 in a forced cycle.
REQ-022 SHALL keep an 8-bit wait_cnt that increments when wr_req=1 and wr_ack=0, and clears when wr_ack=1 or wr_req=0; it never exceeds WR_MAX_WAIT.
REQ-023 SHALL, for a display transfer in cycle N, drive mem_addr=disp_addr and mem_we=0 in cycle N+1, then assert disp_valid with disp_data=mem_rdata in cycle N+2.
REQ-024 SHALL, for a write transfer in cycle N, drive mem_addr=wr_addr, mem_wdata=wr_data and mem_we=1 for exactly cycle N+1; disp_valid is not asserted for writes.
REQ-025 SHALL sustain one display transfer per cycle, with disp_valid following disp_ack by exactly 2 cycles with no gaps inserted.
REQ-026 SHALL, in a cycle with no transfer, drive mem_we=0 in the next cycle and hold mem_addr at its previous value.
REQ-027 SHALL track in-flight reads with a 2-stage valid pipeline; disp_valid is 0 whenever the pipeline stage is empty, and disp_data holds its last value in that case.
REQ-028 SHALL have only two access states, IDLE (no transfer) and a per-cycle owner of DISP or WR; the state is re-evaluated every cycle with no multi-cycle lock.

Reset
REQ-029 SHALL, while rst=1, force disp_ack=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_valid=0, disp_data=0 and wait_cnt=0.
REQ-030 SHALL discard reads in flight when rst asserts: no disp_valid occurs for transfers accepted 1-2 cycles before reset.
REQ-031 SHALL accept requests from the first cycle after rst deasserts.

Verification
REQ-032 SHALL pass this scenario: disp_req held for 10 cycles with addresses 0..9 and wr_req=0 -> disp_ack=1 on all 10 cycles, and disp_valid=1 with data mem[0..9] in order, 2 cycles later each.
REQ-033 SHALL pass this scenario: wr_req=1 with addr 0x100 and data 0xABCD while disp_req=0 -> wr_ack=1 in the same cycle, and the next cycle shows mem_we=1, mem_addr=0x100, mem_wdata=0xABCD.
REQ-034 SHALL pass this scenario: disp_req and wr_req held continuously with WR_MAX_WAIT=8 -> 8 display acks, then 1 writer ack with disp_ack=0, then wait_cnt=0, and the pattern repeats every 9 cycles.
REQ-035 SHALL pass this scenario: wr_req dropped after 5 stall cycles, then reasserted -> wait_cnt restarts at 0, and the forced slot comes 8 cycles after reassertion.
REQ-036 SHALL pass this scenario: rst pulsed 1 cycle after a display transfer -> no disp_valid for that transfer, all outputs 0 during reset, and a normal transfer on the first post-reset cycle.
REQ-037 SHALL pass this scenario: a write to address A at cycle N and a display read of A at cycle N+1 -> disp_valid at N+3 returns the newly written data.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: shares one single-port RAM between display scanout reads and host writes.
// Latency: an accepted request reaches the RAM port 1 cycle later; read data returns 2 cycles after disp_ack.
// Backpressure: requests are held until acked; display wins unless the writer has stalled WR_MAX_WAIT cycles.
//
// Ports:
//   MAX10_CLK1_50, rst                  clock (rising edge) and synchronous active-high reset
//   disp_req/disp_addr -> disp_ack      scanout fetch request and same-cycle accept
//   disp_data/disp_valid                fetched word, valid 2 cycles after disp_ack
//   wr_req/wr_addr/wr_data -> wr_ack    host write request and same-cycle accept
//   mem_addr/mem_wdata/mem_we           registered single-port RAM command
//   mem_rdata                           RAM read data, one cycle after a read address
module vga_fb_arbiter #(
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 16,
   parameter int WR_MAX_WAIT = 8
) (
   input  logic              MAX10_CLK1_50,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_ack,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Owner of the RAM port for the cycle after a transfer; re-decided every cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DISP = 2'd1,
      S_WR   = 2'd2
   } own_e;

   localparam logic [7:0] MAX_WAIT = 8'(WR_MAX_WAIT);

   own_e              state_q,     state_d;
   logic [7:0]        wait_cnt_q,  wait_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              rd_vld2_q,   rd_vld2_d;
   logic [DATA_W-1:0] disp_data_q, disp_data_d;
   logic              force_wr;

   // Grant decision, wait counter and next RAM command.
   always_comb begin
      force_wr    = wr_req && (wait_cnt_q >= MAX_WAIT);
      disp_ack    = 1'b0;
      wr_ack      = 1'b0;
      state_d     = S_IDLE;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wait_cnt_d  = 8'd0;

      if (!rst) begin
         if (disp_req && !force_wr) begin
            disp_ack   = 1'b1;
            state_d    = S_DISP;
            mem_addr_d = disp_addr;
         end else if (wr_req) begin
            wr_ack      = 1'b1;
            state_d     = S_WR;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
         end
      end

      // Counts only stalled writer cycles; any grant or dropped request restarts it.
      // The saturation guard is defensive: a stalled writer at MAX_WAIT is always granted.
      if (wr_req && !wr_ack && (wait_cnt_q < MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      // Stage 1 of the read pipeline is "RAM port owned by display this cycle";
      // stage 2 lines up with mem_rdata coming back.
      rd_vld2_d   = (state_q == S_DISP);
      disp_data_d = rd_vld2_q ? mem_rdata : disp_data_q;
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 8'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_vld2_q   <= 1'b0;
         disp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_vld2_q   <= rd_vld2_d;
         disp_data_q <= disp_data_d;
      end
   end

   // Outputs are forced low for the whole reset pulse, including its first cycle,
   // so a transfer accepted just before reset never reaches the RAM or the display.
   always_comb begin
      mem_we     = (state_q == S_WR) && !rst;
      mem_addr   = rst ? '0 : mem_addr_q;
      mem_wdata  = rst ? '0 : mem_wdata_q;
      disp_valid = rd_vld2_q && !rst;
      // Read data is passed straight through in the return cycle and held afterwards.
      if (rst) begin
         disp_data = '0;
      end else if (rd_vld2_q) begin
         disp_data = mem_rdata;
      end else begin
         disp_data = disp_data_q;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

   localparam int AW = 19;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic          disp_ack;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;

   vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_MAX_WAIT(8)) dut (
      .MAX10_CLK1_50(clk),
      .rst          (rst),
      .disp_req     (disp_req),
      .disp_addr    (disp_addr),
      .disp_ack     (disp_ack),
      .disp_data    (disp_data),
      .disp_valid   (disp_valid),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata)
   );

   always #10 clk = ~clk;

   // Single-port synchronous RAM model (read-before-write, one cycle read latency).
   logic [DW-1:0] ram    [0:1023];
   logic [DW-1:0] shadow [0:1023];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } rd_t;
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } wr_t;

   rd_t rd_q[$];
   wr_t wr_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares whatever the DUT presents against queued expectations.
   always @(negedge clk) begin
      rd_t re;
      wr_t we_e;
      if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
         re = rd_q.pop_front();
         chk("rd_missing_valid_due_cycle", cyc, re.due);
      end
      if (wr_q.size() > 0 && wr_q[0].due < cyc) begin
         we_e = wr_q.pop_front();
         chk("wr_missing_we_due_cycle", cyc, we_e.due);
      end
      if (disp_valid === 1'b1) begin
         if (rd_q.size() == 0) begin
            chk("rd_spurious_valid", 32'(disp_valid), 32'd0);
         end else begin
            re = rd_q.pop_front();
            chk("rd_data", 32'(disp_data), 32'(re.data));
            chk("rd_cycle", cyc, re.due);
         end
      end
      if (mem_we === 1'b1) begin
         if (wr_q.size() == 0) begin
            chk("wr_spurious_we", 32'(mem_we), 32'd0);
         end else begin
            we_e = wr_q.pop_front();
            chk("wr_mem_addr", 32'(mem_addr), 32'(we_e.addr));
            chk("wr_mem_wdata", 32'(mem_wdata), 32'(we_e.data));
            chk("wr_cycle", cyc, we_e.due);
         end
      end
   end

   // One clock of stimulus with hand-derived expected acks.
   task automatic step(input logic dr, input logic [AW-1:0] da,
                       input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic exp_d, input logic exp_w, input string tag);
      disp_req  = dr;
      disp_addr = da;
      wr_req    = wr;
      wr_addr   = wa;
      wr_data   = wd;
      @(negedge clk);
      chk({tag, "_disp_ack"}, 32'(disp_ack), 32'(exp_d));
      chk({tag, "_wr_ack"}, 32'(wr_ack), 32'(exp_w));
      if (exp_d) rd_q.push_back('{shadow[da[9:0]], cyc + 2});
      if (exp_w) begin
         wr_q.push_back('{wa, wd, cyc + 1});
         shadow[wa[9:0]] = wd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
   endtask

   // Reset cycle with requests active: everything must read back zero.
   task automatic reset_cycle(input string tag);
      rst       = 1'b1;
      disp_req  = 1'b1;
      disp_addr = 19'h00077;
      wr_req    = 1'b1;
      wr_addr   = 19'h00078;
      wr_data   = 16'hFFFF;
      rd_q.delete();
      wr_q.delete();
      @(negedge clk);
      chk({tag, "_disp_ack"},   32'(disp_ack),   32'd0);
      chk({tag, "_wr_ack"},     32'(wr_ack),     32'd0);
      chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
      chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
      chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
      chk({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
      chk({tag, "_disp_data"},  32'(disp_data),  32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  wn;
      logic ew;
      for (int i = 0; i < 1024; i++) begin
         ram[i]    = 16'h5A00 ^ 16'(i * 7);
         shadow[i] = 16'h5A00 ^ 16'(i * 7);
      end
      rst = 1'b1;
      disp_req = 1'b0; disp_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      @(posedge clk); #1;
      reset_cycle("reset0");
      reset_cycle("reset1");
      rst = 1'b0;

      // Back-to-back display fetches from the first post-reset cycle, addresses 0..9.
      for (int k = 0; k < 10; k++)
         step(1'b1, 19'(k), 1'b0, '0, '0, 1'b1, 1'b0, "s32");
      idle(3, "idle_a");
      // No transfer: address held from the last fetch, no write strobe.
      @(negedge clk);
      chk("idle_mem_addr_hold", 32'(mem_addr), 32'd9);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;

      // Lone write is granted immediately.
      step(1'b0, '0, 1'b1, 19'h00100, 16'hABCD, 1'b0, 1'b1, "s33");
      idle(2, "idle_b");

      // Write then immediate read of the same word returns the new value.
      step(1'b0, '0, 1'b1, 19'h00005, 16'h1234, 1'b0, 1'b1, "s37w");
      step(1'b1, 19'h00005, 1'b0, '0, '0, 1'b1, 1'b0, "s37r");
      idle(3, "idle_c");

      // Contention: 8 display slots then one forced writer slot, repeating.
      wn = 0;
      for (int k = 0; k < 18; k++) begin
         ew = ((k % 9) == 8);
         step(1'b1, 19'h00020 + 19'(k), 1'b1, 19'h00200 + 19'(wn), 16'hC000 + 16'(wn),
              !ew, ew, "s34");
         if (ew) wn++;
      end
      idle(3, "idle_d");

      // Writer stalls 5 cycles, drops, reasserts: forced slot 8 cycles after reassertion.
      for (int k = 0; k < 5; k++)
         step(1'b1, 19'h00040 + 19'(k), 1'b1, 19'h00210, 16'hD00D, 1'b1, 1'b0, "s35a");
      step(1'b1, 19'h00045, 1'b0, '0, '0, 1'b1, 1'b0, "s35drop");
      for (int k = 0; k < 9; k++) begin
         ew = (k == 8);
         step(1'b1, 19'h00046 + 19'(k), 1'b1, 19'h00211, 16'hD11D, !ew, ew, "s35b");
      end
      idle(3, "idle_e");

      // Reset one cycle after a fetch: that fetch never returns.
      step(1'b1, 19'h00033, 1'b0, '0, '0, 1'b1, 1'b0, "s36pre");
      reset_cycle("s36rst");
      rst = 1'b0;
      step(1'b1, 19'h00035, 1'b0, '0, '0, 1'b1, 1'b0, "s36post");
      idle(6, "drain");

      chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
